ocm_swio: RTL and testbench
===========================

Name: ocm_swio

Overview:
- Switched-I/O register file for the OCM device: decodes CPU I/O ports 0x40-0x4F, the same window the OCM boot stage snoops.
- Owns the manufacturer ID select register, the 1chipMSX extension registers and a smart-command FIFO toward the host/HPS side.
- Produces registered read data and configuration outputs (JIS2, port F4 mode, virtual DIP switches) for neighbouring devices.
- `boot_active` is the preboot-enable flag from the OCM boot stage; it gates the IPL-reserved ports.

Parameters:
- CMD_FIFO_DEPTH, 4, smart-command FIFO entries; power of two, 2..8.
- ID_MSX, 8'h08, manufacturer ID 008.
- ID_OCM, 8'hD4, manufacturer ID 212 (1chipMSX); enables ports 0x41-0x4F.

Ports:
- clk  in  1  system clock (cpu_bus.clk).
- reset  in  1  asynchronous, active-high reset (cpu_bus.reset).
- req  in  1  one-cycle access strobe per CPU bus cycle.
- iorq  in  1  I/O request.
- m1  in  1  opcode-fetch cycle; I/O access ignored when high.
- rd  in  1  read cycle.
- wr  in  1  write cycle.
- addr  in  8  I/O port address.
- data_in  in  8  CPU write data.
- boot_active  in  1  preboot/IPL phase active.
- data_out  out  8  registered read data.
- data_out_valid  out  1  one-cycle qualifier for data_out.
- cmd_data  out  8  FIFO head.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer pop.
- cmd_overflow  out  1  sticky: command dropped on full FIFO.
- io40_n  out  8  inverted selected ID (F7 = 08, 2B = D4, FF = none).
- jis2_ena  out  1  JIS2 enabler.
- portf4_mode  out  1  port F4 mode.
- warm_logo_off  out  1  MSX logo suppressed after warm reset.
- dip_sw  out  8  virtual DIP switch byte.

Behaviour:
- Decode: hit = req & iorq & ~m1 & addr[7:4]==4'h4. Write when hit&wr; read when hit&rd&~wr. rd and wr both high is a write only.
- Reset values (asynchronous):
  - io40_n=FF, dip_sw=00, jis2_ena=0, portf4_mode=0, warm_logo_off=0.
  - FIFO empty: cmd_valid=0, cmd_data=00.
  - cmd_overflow=0, data_out=FF, data_out_valid=0.
- ocm_sel = (io40_n == 8'h2B).
- Writes (take effect the cycle after the strobe):
  - 0x40, always: io40_n <= data_in==ID_MSX ? F7 : data_in==ID_OCM ? 2B : FF.
  - 0x41, ocm_sel: push data_in. When full and no pop in the same cycle: drop it and set cmd_overflow.
  - 0x42, ocm_sel: dip_sw <= data_in.
  - 0x4E, ocm_sel & boot_active: jis2_ena <= ~data_in[7].
  - 0x4F, ocm_sel & boot_active: portf4_mode <= ~data_in[7]; warm_logo_off <= ~data_in[7].
  - All other writes ignored, including any write with ocm_sel=0 except 0x40.
- Reads: latency 1. Cycle after a read strobe: data_out_valid=1 with the value below; in every other cycle data_out_valid=0 and data_out=FF.
  - 0x40: ~io40_n (08, D4 or 00).
  - 0x41 (ocm_sel): {cmd_overflow, 3'b000, count[3:0]}; cmd_overflow clears in the same cycle the status is presented. A set event in that cycle wins.
  - 0x42 (ocm_sel): dip_sw.
  - Everything else (0x4E/0x4F are write-only, or ocm_sel=0): FF.
- FIFO:
  - Circular buffer with wrap-around pointers; count in 0..CMD_FIFO_DEPTH.
  - cmd_valid = count!=0; cmd_data = head entry, 00 when empty. Pop on cmd_valid & cmd_ready.
  - Push and pop in the same cycle: both happen and count is unchanged, including when full (no overflow).
  - Pop on empty and cmd_ready with no valid: no effect.
- Changing the ID select does not flush the FIFO or clear registers. Registers only become inaccessible.
- Reset mid-operation: all state returns to reset values immediately; queued commands are lost.

Test Plan:
- Reset, read 0x40 -> data_out=00, valid one cycle after the strobe. Write 0x40<=D4, read 0x40 -> D4, io40_n=2B. Write 0x40<=55 -> io40_n=FF, read 0x40=00.
- io40_n=FF, write 0x42<=A5, read 0x42 -> FF, dip_sw=00. Select D4, repeat -> dip_sw=A5, read returns A5.
- D4 selected, cmd_ready=0:
  - Push 11,22,33,44 -> read 0x41 = 04.
  - Push 55 -> dropped, cmd_overflow=1; read 0x41 = 84, next read 0x41 = 04.
  - Raise cmd_ready -> cmd_data 11,22,33,44 on consecutive cycles, then cmd_valid=0.
- FIFO full with cmd_ready=1 and a 0x41 write in the same cycle -> head popped, new byte accepted, count stays 4, cmd_overflow stays 0.
- boot_active=1, D4 selected, write 0x4F<=00 -> portf4_mode=1, warm_logo_off=1; write 0x4E<=80 -> jis2_ena=0. boot_active=0, write 0x4F<=80 -> outputs unchanged; read 0x4F -> FF.
- Assert reset with 3 queued commands and dip_sw=A5 -> same cycle: cmd_valid=0, dip_sw=00, io40_n=FF, data_out_valid=0. Write with m1=1 to 0x40 -> ignored.

Source files
------------

// File: rtl/ocm_swio_if.sv
// CPU I/O bus and smart-command stream between the OCM CPU side and ocm_swio.
// master = CPU/host side, slave = the switched-I/O register file.
interface ocm_swio_if;
  logic       req;
  logic       iorq;
  logic       m1;
  logic       rd;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_overflow;

  modport master (
    output req, iorq, m1, rd, wr, addr, data_in, cmd_ready,
    input  data_out, data_out_valid, cmd_data, cmd_valid, cmd_overflow
  );

  modport slave (
    input  req, iorq, m1, rd, wr, addr, data_in, cmd_ready,
    output data_out, data_out_valid, cmd_data, cmd_valid, cmd_overflow
  );
endinterface

// File: rtl/ocm_swio.sv
// Switched-I/O register file for ports 0x40-0x4F: manufacturer ID select,
// 1chipMSX extension registers and a smart-command FIFO toward the host.
module ocm_swio #(
  parameter int         CMD_FIFO_DEPTH = 4,
  parameter logic [7:0] ID_MSX         = 8'h08,
  parameter logic [7:0] ID_OCM         = 8'hD4
) (
  input  logic       clk,
  input  logic       reset,
  ocm_swio_if.slave  bus,
  input  logic       boot_active,
  output logic [7:0] io40_n,
  output logic       jis2_ena,
  output logic       portf4_mode,
  output logic       warm_logo_off,
  output logic [7:0] dip_sw
);

  localparam int AW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [3:0] reg_sel;
  } dec_t;

  dec_t          dec;
  logic          hit;
  logic          ocm_sel;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    mem [CMD_FIFO_DEPTH];
  logic          full;
  logic          push_req, push, pop;
  logic          ovf_set, stat_rd;
  logic [7:0]    rd_data;
  logic [7:0]    id_n_next;

  assign hit         = bus.req & bus.iorq & ~bus.m1 & (bus.addr[7:4] == 4'h4);
  assign dec.wr      = hit & bus.wr;
  assign dec.rd      = hit & bus.rd & ~bus.wr;
  assign dec.reg_sel = bus.addr[3:0];

  assign ocm_sel = (io40_n == ~ID_OCM);

  assign full     = (count == (AW+1)'(CMD_FIFO_DEPTH));
  assign pop      = bus.cmd_valid & bus.cmd_ready;
  assign push_req = dec.wr & ocm_sel & (dec.reg_sel == 4'h1);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign stat_rd  = dec.rd & ocm_sel & (dec.reg_sel == 4'h1);

  assign bus.cmd_valid = (count != '0);
  assign bus.cmd_data  = bus.cmd_valid ? mem[rd_ptr] : 8'h00;

  always_comb begin
    id_n_next = 8'hFF;
    if (bus.data_in == ID_MSX)      id_n_next = ~ID_MSX;
    else if (bus.data_in == ID_OCM) id_n_next = ~ID_OCM;
  end

  always_comb begin
    rd_data = 8'hFF;
    case (dec.reg_sel)
      4'h0: rd_data = ~io40_n;
      4'h1: if (ocm_sel) rd_data = {bus.cmd_overflow, 3'b000, 4'(count)};
      4'h2: if (ocm_sel) rd_data = dip_sw;
      default: rd_data = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io40_n             <= 8'hFF;
      dip_sw             <= 8'h00;
      jis2_ena           <= 1'b0;
      portf4_mode        <= 1'b0;
      warm_logo_off      <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.cmd_overflow   <= 1'b0;
      bus.data_out       <= 8'hFF;
      bus.data_out_valid <= 1'b0;
    end else begin
      if (dec.wr) begin
        case (dec.reg_sel)
          4'h0: io40_n <= id_n_next;
          4'h2: if (ocm_sel) dip_sw <= bus.data_in;
          4'hE: if (ocm_sel & boot_active) jis2_ena <= ~bus.data_in[7];
          4'hF: if (ocm_sel & boot_active) begin
            portf4_mode   <= ~bus.data_in[7];
            warm_logo_off <= ~bus.data_in[7];
          end
          default: ;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;

      // Status read clears the sticky flag, but a fresh drop in that cycle wins.
      if (ovf_set)      bus.cmd_overflow <= 1'b1;
      else if (stat_rd) bus.cmd_overflow <= 1'b0;

      bus.data_out       <= dec.rd ? rd_data : 8'hFF;
      bus.data_out_valid <= dec.rd;
    end
  end

endmodule

// File: tb/tb_ocm_swio.sv
// Randomized and directed check of ocm_swio against a queue-based reference
// model of the port 0x40-0x4F register file.
module tb_ocm_swio;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       boot_active;
  logic [7:0] io40_n;
  logic       jis2_ena, portf4_mode, warm_logo_off;
  logic [7:0] dip_sw;

  ocm_swio_if bus ();

  ocm_swio #(.CMD_FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .boot_active  (boot_active),
    .io40_n       (io40_n),
    .jis2_ena     (jis2_ena),
    .portf4_mode  (portf4_mode),
    .warm_logo_off(warm_logo_off),
    .dip_sw       (dip_sw)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: selected manufacturer ID byte (00 = none) and a queue.
  byte unsigned q[$];
  logic [7:0]   m_id, m_dip, m_dout;
  bit           m_ovf, m_jis, m_f4, m_logo, m_dv;

  task automatic m_reset();
    q.delete();
    m_id = 8'h00; m_dip = 8'h00; m_dout = 8'hFF;
    m_ovf = 0; m_jis = 0; m_f4 = 0; m_logo = 0; m_dv = 0;
  endtask

  task automatic m_step(input bit r, io, m, rdd, wrr, input logic [7:0] a, d, input bit rdy);
    bit hit, wrh, rdh, sel, pop, set, clr, do_push;
    logic [7:0] nd;
    hit = r && io && !m && (a[7:4] == 4'h4);
    wrh = hit && wrr;
    rdh = hit && rdd && !wrr;
    sel = (m_id == 8'hD4);
    pop = (q.size() != 0) && rdy;
    set = 0; do_push = 0;
    nd  = 8'hFF;
    if (rdh) begin
      if (a[3:0] == 4'h0) nd = m_id;
      else if (a[3:0] == 4'h1 && sel) nd = {m_ovf, 3'b000, 4'(q.size())};
      else if (a[3:0] == 4'h2 && sel) nd = m_dip;
    end
    clr = rdh && sel && (a[3:0] == 4'h1);
    if (wrh) begin
      if (a[3:0] == 4'h0) m_id = (d == 8'h08) ? 8'h08 : (d == 8'hD4) ? 8'hD4 : 8'h00;
      else if (sel && a[3:0] == 4'h1) begin
        if (q.size() < DEPTH || pop) do_push = 1; else set = 1;
      end
      else if (sel && a[3:0] == 4'h2) m_dip = d;
      else if (sel && boot_active && a[3:0] == 4'hE) m_jis = ~d[7];
      else if (sel && boot_active && a[3:0] == 4'hF) begin m_f4 = ~d[7]; m_logo = ~d[7]; end
    end
    if (pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (set) m_ovf = 1; else if (clr) m_ovf = 0;
    m_dout = nd;
    m_dv   = rdh;
  endtask

  task automatic check_all();
    logic [7:0] exp_n, exp_head;
    exp_n    = ~m_id;
    exp_head = (q.size() != 0) ? q[0] : 8'h00;
    chk("data_out", bus.data_out, m_dout);
    chk("data_out_valid", bus.data_out_valid, m_dv);
    chk("cmd_valid", bus.cmd_valid, q.size() != 0);
    chk("cmd_data", bus.cmd_data, exp_head);
    chk("cmd_overflow", bus.cmd_overflow, m_ovf);
    chk("io40_n", io40_n, exp_n);
    chk("dip_sw", dip_sw, m_dip);
    chk("jis2_ena", jis2_ena, m_jis);
    chk("portf4_mode", portf4_mode, m_f4);
    chk("warm_logo_off", warm_logo_off, m_logo);
  endtask

  task automatic cyc(input bit r, io, m, rdd, wrr, input logic [7:0] a, d, input bit rdy);
    bus.req = r; bus.iorq = io; bus.m1 = m; bus.rd = rdd; bus.wr = wrr;
    bus.addr = a; bus.data_in = d; bus.cmd_ready = rdy;
    m_step(r, io, m, rdd, wrr, a, d, rdy);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic wr_io(input logic [7:0] a, d, input bit rdy);
    cyc(1, 1, 0, 0, 1, a, d, rdy);
  endtask
  task automatic rd_io(input logic [7:0] a, input bit rdy);
    cyc(1, 1, 0, 1, 0, a, 8'h00, rdy);
  endtask
  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, rdy);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset(input bit directed);
    bus.req = 0; bus.cmd_ready = 0;
    #2 reset = 1;
    #1;
    if (directed) begin
      chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
      chk("rst_dip_sw", dip_sw, 8'h00);
      chk("rst_io40_n", io40_n, 8'hFF);
      chk("rst_dout_valid", bus.data_out_valid, 1'b0);
    end
    m_reset();
    check_all();
    @(posedge clk); #1;
    reset = 0;
    check_all();
  endtask

  initial begin
    bus.req = 0; bus.iorq = 0; bus.m1 = 0; bus.rd = 0; bus.wr = 0;
    bus.addr = 0; bus.data_in = 0; bus.cmd_ready = 0;
    boot_active = 0;
    reset = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0;

    // ID select
    rd_io(8'h40, 0);
    chk("rd40_reset", {bus.data_out_valid, bus.data_out}, 9'h100);
    idle(0);
    chk("dv_one_cycle", bus.data_out_valid, 1'b0);
    wr_io(8'h40, 8'hD4, 0);
    chk("io40_n_ocm", io40_n, 8'h2B);
    rd_io(8'h40, 0);
    chk("rd40_ocm", bus.data_out, 8'hD4);
    wr_io(8'h40, 8'h55, 0);
    chk("io40_n_none", io40_n, 8'hFF);
    rd_io(8'h40, 0);
    chk("rd40_none", bus.data_out, 8'h00);

    // DIP switches gated by ID
    wr_io(8'h42, 8'hA5, 0);
    rd_io(8'h42, 0);
    chk("rd42_locked", bus.data_out, 8'hFF);
    chk("dip_locked", dip_sw, 8'h00);
    wr_io(8'h40, 8'hD4, 0);
    wr_io(8'h42, 8'hA5, 0);
    chk("dip_set", dip_sw, 8'hA5);
    rd_io(8'h42, 0);
    chk("rd42", bus.data_out, 8'hA5);

    // FIFO fill, overflow, drain
    wr_io(8'h41, 8'h11, 0);
    wr_io(8'h41, 8'h22, 0);
    wr_io(8'h41, 8'h33, 0);
    wr_io(8'h41, 8'h44, 0);
    rd_io(8'h41, 0);
    chk("stat_full", bus.data_out, 8'h04);
    wr_io(8'h41, 8'h55, 0);
    chk("ovf_set", bus.cmd_overflow, 1'b1);
    rd_io(8'h41, 0);
    chk("stat_ovf", bus.data_out, 8'h84);
    chk("ovf_cleared", bus.cmd_overflow, 1'b0);
    rd_io(8'h41, 0);
    chk("stat_after", bus.data_out, 8'h04);
    chk("head0", bus.cmd_data, 8'h11);
    idle(1); chk("head1", bus.cmd_data, 8'h22);
    idle(1); chk("head2", bus.cmd_data, 8'h33);
    idle(1); chk("head3", bus.cmd_data, 8'h44);
    idle(1); chk("drained", bus.cmd_valid, 1'b0);
    idle(1);

    // Simultaneous push/pop on a full FIFO
    wr_io(8'h41, 8'hA1, 0);
    wr_io(8'h41, 8'hA2, 0);
    wr_io(8'h41, 8'hA3, 0);
    wr_io(8'h41, 8'hA4, 0);
    wr_io(8'h41, 8'hB5, 1);
    chk("pp_head", bus.cmd_data, 8'hA2);
    chk("pp_no_ovf", bus.cmd_overflow, 1'b0);
    rd_io(8'h41, 0);
    chk("pp_count", bus.data_out, 8'h04);

    // Boot-gated registers
    boot_active = 1;
    wr_io(8'h4F, 8'h00, 0);
    chk("f4_set", {portf4_mode, warm_logo_off}, 2'b11);
    wr_io(8'h4E, 8'h00, 0);
    chk("jis_set", jis2_ena, 1'b1);
    wr_io(8'h4E, 8'h80, 0);
    chk("jis_clr", jis2_ena, 1'b0);
    boot_active = 0;
    wr_io(8'h4F, 8'h80, 0);
    chk("f4_locked", {portf4_mode, warm_logo_off}, 2'b11);
    rd_io(8'h4F, 0);
    chk("rd4f", bus.data_out, 8'hFF);

    // Reset with 3 queued commands, right after a read
    idle(1);
    rd_io(8'h42, 0);
    mid_reset(1);
    cyc(1, 1, 1, 0, 1, 8'h40, 8'hD4, 0);
    chk("m1_ignored", io40_n, 8'hFF);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, io, m, rdd, wrr, rdy;
      logic [7:0] a, d;
      int op;
      if (i % 900 == 899) mid_reset(0);
      if ($urandom_range(0, 63) == 0) boot_active = ~boot_active;
      op  = $urandom_range(0, 9);
      r   = (op != 0);
      io  = ($urandom_range(0, 15) != 0);
      m   = ($urandom_range(0, 15) == 0);
      rdd = (op <= 4) || (op == 9);
      wrr = (op >= 5);
      a   = ($urandom_range(0, 9) != 0) ? (8'h40 | 8'($urandom_range(0, 15))) : 8'($urandom);
      if ($urandom_range(0, 1) == 0) a = 8'h40 | 8'($urandom_range(0, 2));
      d   = 8'($urandom);
      if (a == 8'h40 && wrr) begin
        case ($urandom_range(0, 9))
          0: d = 8'h08;
          1, 2: ;
          default: d = 8'hD4;
        endcase
      end
      rdy = ($urandom_range(0, 2) == 0);
      cyc(r, io, m, rdd, wrr, a, d, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
